// File: rtl/cpu_clock_enable_gen.sv
// Programmable clock-enable generator: one-cycle ce pulse every cur_div+1 clocks, with run/halt/single-step.
// Optional macro CE_INPUT_SYNC_EN adds two-flop synchronizers on div/run/step and rising-edge detection of step.
module cpu_clock_enable_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 1,
    parameter int STEP_PULSES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 run,
    input  logic                 step,
    output logic                 ce,
    output logic                 ce_phase,
    output logic [DIV_WIDTH-1:0] cur_div,
    output logic                 halted
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_DEFAULT = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [3:0]           STEP_LOAD   = 4'(STEP_PULSES);

    logic [DIV_WIDTH-1:0] div_in;
    logic                 run_in;
    logic                 step_req;

`ifdef CE_INPUT_SYNC_EN
    // div is synchronized bitwise; it is only consumed at period boundaries,
    // so a transiently skewed value is tolerated as long as div is held stable.
    logic [DIV_WIDTH-1:0] div_s1_q, div_s2_q;
    logic                 run_s1_q, run_s2_q;
    logic                 step_s1_q, step_s2_q, step_s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_s1_q  <= '0;
            div_s2_q  <= '0;
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            div_s1_q  <= div;
            div_s2_q  <= div_s1_q;
            run_s1_q  <= run;
            run_s2_q  <= run_s1_q;
            step_s1_q <= step;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

    assign div_in   = div_s2_q;
    assign run_in   = run_s2_q;
    assign step_req = step_s2_q & ~step_s3_q;
`else
    assign div_in   = div;
    assign run_in   = run;
    assign step_req = step;
`endif

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
    logic [3:0]           step_cnt_q, step_cnt_d;
    logic                 ce_q, ce_d;
    logic                 phase_q, phase_d;
    logic                 tc;

    assign tc = (cnt_q == cur_div_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        step_cnt_d = step_cnt_q;
        ce_d       = 1'b0;
        case (state_q)
            ST_HALT: begin
                // Counter parked at 0, so a new divisor may be taken at any time.
                cnt_d     = '0;
                cur_div_d = div_in;
                if (run_in) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d    = ST_STEP;
                    step_cnt_d = STEP_LOAD;
                end
            end
            ST_RUN: begin
                if (tc) begin
                    cnt_d     = '0;
                    cur_div_d = div_in;
                    ce_d      = 1'b1;
                    if (!run_in) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            ST_STEP: begin
                if (tc) begin
                    cnt_d      = '0;
                    cur_div_d  = div_in;
                    ce_d       = 1'b1;
                    step_cnt_d = step_cnt_q - 4'd1;
                    if (run_in) begin
                        state_d    = ST_RUN;
                        step_cnt_d = '0;
                    end else if (step_cnt_q <= 4'd1) begin
                        state_d    = ST_HALT;
                        step_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
        phase_d = phase_q ^ ce_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            cur_div_q  <= DIV_DEFAULT;
            step_cnt_q <= '0;
            ce_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            step_cnt_q <= step_cnt_d;
            ce_q       <= ce_d;
            phase_q    <= phase_d;
        end
    end

    assign ce       = ce_q;
    assign ce_phase = phase_q;
    assign cur_div  = cur_div_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_clock_enable_gen.sv
// Directed bench for cpu_clock_enable_gen: cycle-by-cycle reference model plus literal timing checks.
module tb_cpu_clock_enable_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div;
    logic        run;
    logic        step;
    logic        ce;
    logic        ce_phase;
    logic [15:0] cur_div;
    logic        halted;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    cpu_clock_enable_gen #(
        .DIV_WIDTH  (16),
        .DEFAULT_DIV(1),
        .STEP_PULSES(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .run     (run),
        .step    (step),
        .ce      (ce),
        .ce_phase(ce_phase),
        .cur_div (cur_div),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=halt 1=run 2=step; ttc = clocks left before the
    // end of the current period; a period ends when ttc reaches zero.
    int m_mode = 0, m_ttc = 0, m_cur = 1, m_steps = 0;
    bit m_ce = 1'b0, m_phase = 1'b0;

    always @(posedge clk) begin : model
        int n_mode, n_ttc, n_cur, n_steps;
        bit n_ce;
        if (reset) begin
            n_mode = 0; n_ttc = 0; n_cur = 1; n_steps = 0; n_ce = 1'b0;
        end else begin
            n_mode = m_mode; n_ttc = m_ttc; n_cur = m_cur; n_steps = m_steps; n_ce = 1'b0;
            if (m_mode == 0) begin
                n_cur = int'(div);
                n_ttc = int'(div);
                if (run) n_mode = 1;
                else if (step) begin
                    n_mode  = 2;
                    n_steps = 3;
                end
            end else if (m_ttc == 0) begin
                n_ce  = 1'b1;
                n_cur = int'(div);
                n_ttc = int'(div);
                if (m_mode == 1) begin
                    if (!run) n_mode = 0;
                end else begin
                    n_steps = m_steps - 1;
                    if (run) n_mode = 1;
                    else if (n_steps == 0) n_mode = 0;
                end
            end else begin
                n_ttc = m_ttc - 1;
            end
        end
        m_mode  <= n_mode;
        m_ttc   <= n_ttc;
        m_cur   <= n_cur;
        m_steps <= n_steps;
        m_ce    <= n_ce;
        m_phase <= reset ? 1'b0 : (m_phase ^ n_ce);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ce", int'(ce), int'(m_ce));
            chk("model_phase", int'(ce_phase), int'(m_phase));
            chk("model_cur_div", int'(cur_div), m_cur);
            chk("model_halted", int'(halted), int'(m_mode == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ce(output int n);
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (ce) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int pos [3];
        bit ok;

        reset = 1'b1; run = 1'b1; div = 16'd1; step = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        $display("phase 1: reset with run=1 div=1");
        chk("rst_ce", int'(ce), 0);
        chk("rst_phase", int'(ce_phase), 0);
        chk("rst_cur_div", int'(cur_div), 1);
        chk("rst_halted", int'(halted), 1);
        reset = 1'b0;
        tick();
        chk("rel_halted", int'(halted), 0);
        tick();
        chk("rel_ce_early", int'(ce), 0);
        tick();
        chk("rel_first_ce", int'(ce), 1);
        chk("rel_first_phase", int'(ce_phase), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce) cnt++;
        end
        chk("div1_ce_count", cnt, 10);

        $display("phase 2: div 3 -> 9 mid-period");
        div = 16'd3;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_cur == 3 && m_ttc == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_cnt1", int'(ok), 1);
        div = 16'd9;
        wait_ce(n);
        chk("old_period_gap", n, 3);
        chk("cur_div_at_tc", int'(cur_div), 9);
        wait_ce(n);
        chk("new_period_gap", n, 10);

        $display("phase 3: div=0 continuous, then run=0");
        div = 16'd0;
        wait_ce(n);
        chk("div0_load_gap", n, 10);
        chk("div0_cur_div", int'(cur_div), 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ce) cnt++;
        end
        chk("div0_continuous", cnt, 5);
        run = 1'b0;
        tick();
        chk("stop_last_ce", int'(ce), 1);
        chk("stop_halted", int'(halted), 1);
        tick();
        chk("stop_ce_drop", int'(ce), 0);

        $display("phase 4: single step div=4 with extra step during STEP");
        div = 16'd4;
        tick();
        tick();
        step = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            step = (i == 7);
            if (ce) begin
                if (cnt < 3) pos[cnt] = i;
                cnt++;
            end
        end
        chk("step_count", cnt, 3);
        chk("step_pos0", pos[0], 6);
        chk("step_pos1", pos[1], 11);
        chk("step_pos2", pos[2], 16);
        chk("step_end_halted", int'(halted), 1);

        $display("phase 5: run and step together from halt, div=2");
        div = 16'd2;
        run = 1'b1;
        step = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            step = 1'b0;
            if (ce) cnt++;
        end
        chk("run_wins_count", cnt, 9);
        chk("run_wins_halted", int'(halted), 0);

        $display("phase 6: reset during STEP");
        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_halt", int'(ok), 1);
        div = 16'd4;
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_ce(n);
        chk("rstep_first_gap", n, 5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstep_ce", int'(ce), 0);
        chk("rstep_phase", int'(ce_phase), 0);
        chk("rstep_cur_div", int'(cur_div), 1);
        chk("rstep_halted", int'(halted), 1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce) cnt++;
        end
        chk("rstep_no_ce", cnt, 0);
        run = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_clock_enable_gen.md
Name: cpu_clock_enable_gen

Overview:
Programmable clock-enable generator for the CPU core; replaces fixed divided clocks with a single-clock enable scheme. It derives a one-cycle enable pulse and a 50%-style phase signal from the board clock. The divide ratio is selectable at runtime and changes without glitches. Adds halt and single-step modes for board-level debug from slide switches and buttons.

Parameters:
DIV_WIDTH, 16, width of divisor input and internal counter
DEFAULT_DIV, 1, divisor loaded at reset (period = DEFAULT_DIV+1 cycles)
STEP_PULSES, 1, number of ce pulses issued per single-step request (1..15)

Ports:
clk  in  1  board clock; all logic on posedge
reset  in  1  synchronous, active-high
div  in  DIV_WIDTH  requested divisor N; ce period = N+1 clk cycles
run  in  1  level; 1 = free-run, 0 = halt
step  in  1  single-cycle request pulse; honoured only while halted
ce  out  1  one-clk-wide enable pulse to CPU datapath
ce_phase  out  1  toggles on every ce; divided-clock equivalent for scope/LED
cur_div  out  DIV_WIDTH  divisor currently in effect
halted  out  1  1 when in HALT state with no step in progress

Behaviour:
- Reset (synchronous, active-high): state=HALT if run==0 else RUN takes effect the cycle after reset deasserts; during reset: cnt=0, cur_div=DEFAULT_DIV, ce=0, ce_phase=0, halted=1, step counter=0.
- Counter: cnt counts 0..cur_div, wraps to 0. Terminal count (tc) = (cnt==cur_div). Arithmetic is unsigned, DIV_WIDTH bits, no overflow possible since cnt<=cur_div.
- Divisor change: div sampled into cur_div only at tc (or while HALT with cnt==0); never mid-period. Period in progress always completes with old value.
- N=0: tc every cycle; ce high continuously while RUN.
- ce registered: ce=1 in the cycle after tc while pulse permitted; latency tc→ce = 1 clk.
- ce_phase toggles in the same cycle ce is 1.
- States:
  RUN: counter free-runs; ce on every tc. run==0 → HALT at next tc (the pending period finishes, its ce is issued); counter then held at 0.
  HALT: counter held at 0, ce=0, halted=1. run==1 → RUN next cycle. step==1 (and run==0) → STEP, load step counter=STEP_PULSES.
  STEP: counter runs; each tc issues ce and decrements step counter; at 0 → HALT, counter held at 0. halted=0 in STEP. step pulses while in STEP ignored. run==1 in STEP → RUN after current tc (remaining steps discarded).
- Simultaneous run==1 and step==1 in HALT: run wins, step dropped.
- step while RUN: ignored.
- reset mid-period or mid-step: all state cleared per reset values; no partial ce.

Optional Feature:
CE_INPUT_SYNC_EN: when defined, div, run and step pass through two-flop synchronizers before use, and step is edge-detected (rising edge of synchronized step = one request); all input-to-effect latencies grow by 2 clk. When undefined, inputs are used directly, step is treated as a pre-formed single-cycle pulse, and the caller guarantees synchrony to clk.

Test Plan:
- Reset with DEFAULT_DIV=1, run=1, hold 20 cycles -> ce pulses every 2 clk, first ce 3 clk after reset release, ce_phase toggles each ce, cur_div=1, halted=0.
- run=1, div changed 3→9 at cnt=1 -> remaining period keeps 4-cycle spacing; next period 10 cycles; cur_div updates exactly at tc.
- div=0, run=1 -> ce=1 every cycle; then run=0 -> ce drops after one more cycle, halted=1, cnt=0.
- Halted, div=4, STEP_PULSES=3, step pulse -> exactly 3 ce pulses 5 clk apart, then halted=1; second step pulse during STEP yields no extra pulses.
- Halted, run=1 and step=1 same cycle -> RUN entered, continuous ce at div rate, no STEP behaviour.
- reset asserted mid-STEP after 1 of 3 pulses -> ce=0, ce_phase=0, cur_div=DEFAULT_DIV next cycle; no further ce until run=1.
